// File: rtl/instr_cache.sv
// Direct-mapped instruction cache: 8 sets of 16-byte blocks, combinational hit path,
// 3-state refill FSM. Define ICACHE_STATS_EN to add HIT_COUNT / MISS_COUNT outputs.
module instr_cache (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  ADDRESS,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSY_WAIT,
  output logic         MEM_READ,
  output logic [27:0]  MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSY_WAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  HIT_COUNT,
  output logic [31:0]  MISS_COUNT
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } state_t;

  state_t       r_state;
  logic [7:0]   r_valid;
  logic [24:0]  r_tag  [8];
  logic [127:0] r_data [8];

  logic [2:0]   w_idx;
  logic [24:0]  w_tag;
  logic [1:0]   w_word;
  logic         w_hit;
  logic         w_unused_addr;

  assign w_idx         = ADDRESS[6:4];
  assign w_tag         = ADDRESS[31:7];
  assign w_word        = ADDRESS[3:2];
  assign w_unused_addr = ^ADDRESS[1:0];

  assign w_hit       = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign INSTRUCTION = r_data[w_idx][{w_word, 5'd0} +: 32];

  // Handshake outputs decode the state; RESET masks the stall so the PC can load unstalled.
  always_comb begin
    BUSY_WAIT   = 1'b0;
    MEM_READ    = 1'b0;
    MEM_ADDRESS = 28'd0;
    if (!RESET) begin
      case (r_state)
        S_IDLE: begin
          BUSY_WAIT = ~w_hit;
        end
        S_MEM_READ: begin
          BUSY_WAIT   = 1'b1;
          MEM_READ    = 1'b1;
          MEM_ADDRESS = ADDRESS[31:4];
        end
        S_UPDATE: begin
          BUSY_WAIT = 1'b1;
        end
        default: begin
          BUSY_WAIT = 1'b0;
        end
      endcase
    end else begin
      BUSY_WAIT   = 1'b0;
      MEM_READ    = 1'b0;
      MEM_ADDRESS = 28'd0;
    end
  end

  // Refill FSM and valid bits; reset abandons any refill in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_valid <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= w_hit ? S_IDLE : S_MEM_READ;
        end
        S_MEM_READ: begin
          r_state <= MEM_BUSY_WAIT ? S_MEM_READ : S_UPDATE;
        end
        S_UPDATE: begin
          r_state        <= S_IDLE;
          r_valid[w_idx] <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Tag/data arrays need no reset: they are only observed through the valid bits.
  always_ff @(posedge CLK) begin
    if (!RESET && (r_state == S_UPDATE)) begin
      r_data[w_idx] <= MEM_READDATA;
      r_tag[w_idx]  <= w_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic        r_after_update;
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // The IDLE cycle right after a refill is the stalled fetch completing, not a fresh hit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_after_update <= 1'b0;
      r_hit_count    <= 32'd0;
      r_miss_count   <= 32'd0;
    end else begin
      r_after_update <= (r_state == S_UPDATE);
      if ((r_state == S_IDLE) && !w_hit) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
      if ((r_state == S_IDLE) && w_hit && !r_after_update) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
    end
  end

  assign HIT_COUNT  = r_hit_count;
  assign MISS_COUNT = r_miss_count;
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed scenarios plus randomized fetches
// against a block-address-level cache model and a synthetic instruction memory.
module tb_instr_cache;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  ADDRESS;
  logic [31:0]  INSTRUCTION;
  logic         BUSY_WAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSY_WAIT;
`ifdef ICACHE_STATS_EN
  logic [31:0]  HIT_COUNT;
  logic [31:0]  MISS_COUNT;
`endif

  instr_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ADDRESS      (ADDRESS),
    .INSTRUCTION  (INSTRUCTION),
    .BUSY_WAIT    (BUSY_WAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSY_WAIT(MEM_BUSY_WAIT)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] salt [4];
  // Reference model: which 16-byte block (ADDRESS[31:4]) each set currently holds.
  bit          m_valid [8];
  logic [27:0] m_blk   [8];
  int          m_hits;
  int          m_misses;

  function automatic logic [127:0] mem_block(input logic [27:0] ba);
    logic [127:0] b;
    logic [1:0]   wi;
    for (int i = 0; i < 4; i++) begin
      wi = i[1:0];
      b[i*32 +: 32] = {ba, wi, 2'b11} ^ salt[i];
    end
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_blk[i]   = 28'd0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  // One complete fetch; memory drops its busy in MEM_READ cycle k of a miss.
  task automatic fetch(input logic [31:0] addr, input int k, input string name);
    logic [2:0]   idx;
    logic [27:0]  ba;
    bit           hit;
    bit           last;
    bit           exp_busy;
    bit           exp_mr;
    logic [27:0]  exp_ma;
    logic [127:0] blk;
    logic [31:0]  exp_word;
    int           total;
    int           w;
    ba       = addr[31:4];
    idx      = addr[6:4];
    w        = int'(addr[3:2]);
    hit      = m_valid[idx] && (m_blk[idx] == ba);
    blk      = mem_block(ba);
    exp_word = blk[w*32 +: 32];
    total    = hit ? 1 : k + 3;
    ADDRESS  = addr;
    for (int c = 0; c < total; c++) begin
      MEM_BUSY_WAIT = (c < k);
      MEM_READDATA  = (!hit && c >= k) ? blk : {$urandom, $urandom, $urandom, $urandom};
      @(negedge CLK);
      last     = (c == total - 1);
      exp_busy = !last;
      exp_mr   = !hit && (c >= 1) && (c <= k);
      exp_ma   = exp_mr ? ba : 28'd0;
      n_cmp++;
      if (BUSY_WAIT !== exp_busy) begin
        n_bad++;
        $display("FAIL %s busy_wait cycle %0d addr %h: got %b want %b", name, c, addr, BUSY_WAIT, exp_busy);
      end
      n_cmp++;
      if (MEM_READ !== exp_mr) begin
        n_bad++;
        $display("FAIL %s mem_read cycle %0d addr %h: got %b want %b", name, c, addr, MEM_READ, exp_mr);
      end
      n_cmp++;
      if (MEM_ADDRESS !== exp_ma) begin
        n_bad++;
        $display("FAIL %s mem_address cycle %0d addr %h: got %h want %h", name, c, addr, MEM_ADDRESS, exp_ma);
      end
      if (last) begin
        n_cmp++;
        if (INSTRUCTION !== exp_word) begin
          n_bad++;
          $display("FAIL %s instruction addr %h: got %h want %h", name, addr, INSTRUCTION, exp_word);
        end
      end
      @(posedge CLK); #1;
    end
    if (hit) begin
      m_hits++;
    end else begin
      m_valid[idx] = 1'b1;
      m_blk[idx]   = ba;
      m_misses++;
    end
  endtask

  task automatic test_reset();
    RESET         = 1'b1;
    ADDRESS       = $urandom;
    MEM_BUSY_WAIT = 1'b1;
    MEM_READDATA  = 128'd0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      n_cmp++;
      if (BUSY_WAIT !== 1'b0) begin
        n_bad++;
        $display("FAIL reset busy_wait: got %b want 0", BUSY_WAIT);
      end
      n_cmp++;
      if (MEM_READ !== 1'b0) begin
        n_bad++;
        $display("FAIL reset mem_read: got %b want 0", MEM_READ);
      end
      @(posedge CLK); #1;
    end
    RESET = 1'b0;
    model_clear();
`ifdef ICACHE_STATS_EN
    n_cmp++;
    if ((HIT_COUNT !== 32'd0) || (MISS_COUNT !== 32'd0)) begin
      n_bad++;
      $display("FAIL reset counters: got hit %0d miss %0d want 0 0", HIT_COUNT, MISS_COUNT);
    end
`endif
  endtask

  task automatic test_first_refill();
    fetch(32'h0000_0000, 5, "first_refill");
  endtask

  task automatic test_sequential_hits();
    fetch(32'h0000_0004, 3, "seq_hit_w1");
    fetch(32'h0000_0008, 3, "seq_hit_w2");
    fetch(32'h0000_000C, 3, "seq_hit_w3");
  endtask

  task automatic test_eviction();
    fetch(32'h0000_0080, 2, "evict_new");
    fetch(32'h0000_0000, 3, "evict_old");
  endtask

  task automatic test_k1();
    fetch(32'h0000_0154, 1, "k1_miss");
    fetch(32'h0000_0158, 1, "k1_hit");
  endtask

  task automatic test_pc_reset_value();
    fetch(32'hFFFF_FFFC, 3, "pc_reset_miss");
    fetch(32'hFFFF_FFF0, 3, "pc_reset_hit");
  endtask

  task automatic test_reset_abort();
    logic [31:0] addr;
    addr          = 32'h0000_0268;
    ADDRESS       = addr;
    MEM_BUSY_WAIT = 1'b1;
    MEM_READDATA  = mem_block(addr[31:4]);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        RESET = 1'b1;
      end
      @(negedge CLK);
      n_cmp++;
      if (MEM_READ !== (c == 1)) begin
        n_bad++;
        $display("FAIL abort mem_read cycle %0d: got %b want %b", c, MEM_READ, (c == 1));
      end
      n_cmp++;
      if (BUSY_WAIT !== (c != 2)) begin
        n_bad++;
        $display("FAIL abort busy_wait cycle %0d: got %b want %b", c, BUSY_WAIT, (c != 2));
      end
      @(posedge CLK); #1;
    end
    RESET = 1'b0;
    model_clear();
    fetch(addr, 2, "abort_refetch");
  endtask

  task automatic test_random();
    logic [24:0] tag;
    logic [2:0]  idx;
    logic [1:0]  word;
    logic [1:0]  lo;
    for (int n = 0; n < 150; n++) begin
      tag  = ($urandom_range(0, 7) == 0) ? 25'($urandom) : 25'($urandom_range(0, 2));
      idx  = 3'($urandom_range(0, 7));
      word = 2'($urandom_range(0, 3));
      lo   = 2'($urandom_range(0, 3));
      fetch({tag, idx, word, lo}, $urandom_range(1, 6), "random");
    end
`ifdef ICACHE_STATS_EN
    n_cmp++;
    if ((HIT_COUNT !== 32'(m_hits)) || (MISS_COUNT !== 32'(m_misses))) begin
      n_bad++;
      $display("FAIL random counters: got hit %0d miss %0d want %0d %0d", HIT_COUNT, MISS_COUNT, m_hits, m_misses);
    end
`endif
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_clear();
    fetch(32'h0000_0000, 2, "stats_0");
    fetch(32'h0000_0004, 2, "stats_4");
    fetch(32'h0000_0008, 2, "stats_8");
    fetch(32'h0000_0080, 2, "stats_80");
    n_cmp++;
    if (MISS_COUNT !== 32'd2) begin
      n_bad++;
      $display("FAIL stats miss_count: got %0d want 2", MISS_COUNT);
    end
    n_cmp++;
    if (HIT_COUNT !== 32'd2) begin
      n_bad++;
      $display("FAIL stats hit_count: got %0d want 2", HIT_COUNT);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) begin
      salt[i] = $urandom;
    end
    test_reset();
    test_first_refill();
    test_sequential_hits();
    test_eviction();
    test_k1();
    test_pc_reset_value();
    test_reset_abort();
    test_random();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
